// File: rtl/mm_arb_pkg.sv
// Shared types and default sizing for the multi-master FIFO write-port arbiter.
package mm_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DW        = 32;
    localparam int DEF_MAX_BEATS = 16;

endpackage

// File: rtl/mm_req_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first valid index at or above ptr_i, wrapping to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] winner_o,
    output logic          any_valid_o
);

    logic found;

    // Two ascending passes (ptr..N-1, then 0..ptr-1) avoid a modulo in the index path.
    always_comb begin
        winner_o    = '0;
        found       = 1'b0;
        any_valid_o = |valid_i;
        for (int j = 0; j < N; j++) begin
            if (!found && (j >= int'(ptr_i)) && valid_i[j]) begin
                found    = 1'b1;
                winner_o = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && (j < int'(ptr_i)) && valid_i[j]) begin
                found    = 1'b1;
                winner_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mm_req_arbiter.sv
// Packet-locked round-robin arbiter funnelling NUM_REQ beat streams into one FIFO write port.
//  state  | meaning
//  IDLE   | no grant; pick next requester, one-cycle bubble before the first write
//  LOCKED | grant_id owns the FIFO port until last beat or MAX_BEATS accepted
module mm_req_arbiter
    import mm_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DW        = DEF_DW,
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    parameter int IW        = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DW-1:0]         fifo_data,
    output logic [IW-1:0]         grant_id,
    output logic                  busy,
    output logic                  overrun
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          overrun_q, overrun_d;

    logic [IW-1:0] winner;
    logic          any_valid;
    logic          sel_valid, sel_last, accept;
    logic [DW-1:0] sel_data;
    logic [IW-1:0] grant_inc;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
        .valid_i     (req_valid),
        .ptr_i       (rr_ptr_q),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_q == IW'(j)) begin
                sel_valid = req_valid[j];
                sel_last  = req_last[j];
                sel_data  = req_data[j*DW +: DW];
            end
        end
    end

    assign grant_inc = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        overrun_d  = overrun_q;
        req_ready  = '0;
        accept     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d    = winner;
                    beat_cnt_d = '0;
                    state_d    = LOCKED;
                end
            end
            LOCKED: begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    req_ready[j] = (grant_q == IW'(j)) && !fifo_full;
                end
                accept = sel_valid && !fifo_full;
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (sel_last || (beat_cnt_q == CW'(MAX_BEATS - 1))) begin
                        state_d  = IDLE;
                        rr_ptr_d = grant_inc;
                        // A last beat landing exactly on MAX_BEATS is a clean finish.
                        if (!sel_last) begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign fifo_wr_en = accept;
    assign fifo_data  = sel_data;
    assign grant_id   = grant_q;
    assign busy       = (state_q == LOCKED);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_mm_req_arbiter.sv
// Directed bench for mm_req_arbiter: round-robin order, multi-beat lock, stall, overrun, async reset.
module tb_mm_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int IW      = 2;

    logic                  clk = 1'b0;
    logic                  rst_;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_last;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [DW-1:0]         fifo_data;
    logic [IW-1:0]         grant_id;
    logic                  busy;
    logic                  overrun;

    int errors = 0;
    int checks = 0;

    mm_req_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .MAX_BEATS(16)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] beat_val(input int req, input int beat);
        return 32'hA000_0000 | (req << 8) | beat;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_beat(input int req, input int beat, input logic last);
        req_data[req*DW +: DW] = beat_val(req, beat);
        req_last[req]          = last;
    endtask

    initial begin
        rst_      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        #1;
        chk("rst_busy",    busy,       0);
        chk("rst_ready",   req_ready,  0);
        chk("rst_wr",      fifo_wr_en, 0);
        chk("rst_grant",   grant_id,   0);
        chk("rst_overrun", overrun,    0);
        tick();
        tick();
        rst_ = 1'b1;
        tick();

        // All four requesters with single-beat packets: strict 0,1,2,3 with a bubble before each.
        req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_beat(i, 0, 1'b1);
        for (int i = 0; i < NUM_REQ; i++) begin
            #1;
            chk("rr_idle_busy", busy,       0);
            chk("rr_idle_wr",   fifo_wr_en, 0);
            chk("rr_idle_rdy",  req_ready,  0);
            tick();
            #1;
            chk("rr_grant", grant_id,   i);
            chk("rr_busy",  busy,       1);
            chk("rr_wr",    fifo_wr_en, 1);
            chk("rr_data",  fifo_data,  beat_val(i, 0));
            chk("rr_ready", req_ready,  4'b0001 << i);
            tick();
        end
        req_valid = '0;
        tick();

        // Move the pointer to 2 with a lone packet from requester 1.
        req_valid = 4'b0010;
        tick();
        #1;
        chk("pre_grant1", grant_id, 1);
        tick();
        req_valid = 4'b0101;
        set_beat(0, 0, 1'b1);
        set_beat(2, 0, 1'b0);
        tick();
        for (int b = 0; b < 3; b++) begin
            set_beat(2, b, b == 2);
            #1;
            chk("mb_grant", grant_id,   2);
            chk("mb_wr",    fifo_wr_en, 1);
            chk("mb_data",  fifo_data,  beat_val(2, b));
            chk("mb_rdy0",  req_ready[0], 0);
            tick();
        end
        req_valid[2] = 1'b0;
        #1;
        chk("mb_idle",   busy,         0);
        chk("mb_rrptr",  dut.rr_ptr_q, 3);
        tick();
        #1;
        chk("mb_next_grant", grant_id, 0);
        chk("mb_next_data",  fifo_data, beat_val(0, 0));
        tick();
        req_valid = '0;
        tick();

        // Stall for four cycles in the middle of a three-beat packet from requester 3.
        req_valid = 4'b1000;
        set_beat(3, 0, 1'b0);
        tick();
        #1;
        chk("st_grant", grant_id,   3);
        chk("st_wr0",   fifo_wr_en, 1);
        tick();
        set_beat(3, 1, 1'b0);
        fifo_full = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("st_wr",   fifo_wr_en,     0);
            chk("st_rdy",  req_ready,      0);
            chk("st_busy", busy,           1);
            chk("st_data", fifo_data,      beat_val(3, 1));
            chk("st_cnt",  dut.beat_cnt_q, 1);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        chk("st_wr1",   fifo_wr_en, 1);
        chk("st_data1", fifo_data,  beat_val(3, 1));
        tick();
        set_beat(3, 2, 1'b1);
        #1;
        chk("st_wr2", fifo_wr_en, 1);
        tick();
        req_valid = '0;
        #1;
        chk("st_done", busy, 0);
        tick();

        // Requester 1 streams without last: forced release after exactly 16 beats.
        req_valid = 4'b0010;
        set_beat(1, 0, 1'b0);
        tick();
        for (int b = 0; b < 16; b++) begin
            set_beat(1, b, 1'b0);
            #1;
            chk("ov_wr",      fifo_wr_en, 1);
            chk("ov_grant",   grant_id,   1);
            chk("ov_pending", overrun,    0);
            tick();
        end
        set_beat(1, 16, 1'b0);
        #1;
        chk("ov_idle",  busy,       0);
        chk("ov_nowr",  fifo_wr_en, 0);
        chk("ov_flag",  overrun,    1);
        chk("ov_rrptr", dut.rr_ptr_q, 2);
        req_valid = 4'b0011;
        set_beat(0, 0, 1'b1);
        tick();
        #1;
        chk("ov_regrant", grant_id, 0);
        chk("ov_wr_r0",   fifo_wr_en, 1);
        tick();
        req_valid = '0;
        #1;
        chk("ov_sticky", overrun, 1);
        tick();

        // Asynchronous reset two beats into a five-beat packet.
        req_valid = 4'b1000;
        set_beat(3, 0, 1'b0);
        tick();
        #1;
        chk("ar_grant", grant_id, 3);
        tick();
        set_beat(3, 1, 1'b0);
        #1;
        chk("ar_wr1", fifo_wr_en, 1);
        tick();
        set_beat(3, 2, 1'b0);
        rst_ = 1'b0;
        #1;
        chk("ar_busy",    busy,       0);
        chk("ar_ready",   req_ready,  0);
        chk("ar_wr",      fifo_wr_en, 0);
        chk("ar_overrun", overrun,    0);
        chk("ar_grant0",  grant_id,   0);
        tick();
        req_valid = 4'b1010;
        set_beat(1, 0, 1'b1);
        set_beat(3, 0, 1'b1);
        rst_ = 1'b1;
        #1;
        chk("ar_idle", busy, 0);
        tick();
        #1;
        chk("ar_first_grant", grant_id,  1);
        chk("ar_first_data",  fifo_data, beat_val(1, 0));
        tick();
        req_valid = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
